johnson_phase_monitor: RTL and testbench

//  Downstream consumer of the 6-bit twisted-ring (Johnson) shift register. Samples its q word
//  and LD strobe, decodes the phase (0..2W-1) and checks each step is the legal successor.

---
 rtl/jpm_pkg.sv | 18 +
 rtl/johnson_decode.sv | 33 +++
 rtl/johnson_phase_monitor.sv | 132 +++++++++++++
 tb/tb_johnson_phase_monitor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jpm_pkg.sv
// Shared types and defaults for the Johnson phase monitor.
// Optional build macro: JPM_BIDIR_EN (reverse-direction stepping).
package jpm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } jpm_state_e;

  function automatic int phase_w(input int w);
    return $clog2(2 * w);
  endfunction

  localparam int JPM_W  = 6;
  localparam int JPM_CW = 8;

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: W-bit word -> phase 0..2W-1 plus legal flag.
// Fill phases are k ones from the LSB; drain phases are the all-ones word shifted left by j.
module johnson_decode
  import jpm_pkg::*;
#(
  parameter int W = JPM_W
) (
  input  logic [W-1:0]          q,
  output logic [phase_w(W)-1:0] phase,
  output logic                  legal
);

  localparam int PW = phase_w(W);
  localparam logic [W-1:0] ONES = '1;

  always_comb begin
    phase = '0;
    legal = 1'b0;
    for (int k = 0; k <= W; k++) begin
      if (q == W'((1 << k) - 1)) begin
        phase = PW'(k);
        legal = 1'b1;
      end
    end
    for (int j = 1; j < W; j++) begin
      if (q == (ONES << j)) begin
        phase = PW'(W + j);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks an upstream Johnson counter: checks each step is the legal successor, flags
// illegal codes and skips, counts revolutions. Define JPM_BIDIR_EN to accept reverse steps.
module johnson_phase_monitor
  import jpm_pkg::*;
#(
  parameter int W  = JPM_W,
  parameter int CW = JPM_CW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          q_in,
  input  logic                  ld_in,
  input  logic                  err_clr,
  output logic [phase_w(W)-1:0] phase,
  output logic                  phase_vld,
  output logic                  illegal,
  output logic                  step_err,
  output logic [CW-1:0]         err_cnt,
  output logic                  rev_tick,
  output logic [CW-1:0]         rev_count,
  output logic                  dir
);

  localparam int PW = phase_w(W);
  localparam logic [PW-1:0] LAST = PW'(2 * W - 1);
  localparam logic [CW-1:0] CMAX = '1;

  jpm_state_e    state_q, state_d;
  logic [PW-1:0] dec_phase, succ, pred, phase_d;
  logic          dec_legal, vld_d, ill_d, serr_d, tick_d, dir_d, err_inc;
  logic [CW-1:0] ecnt_d, rcnt_d;

  johnson_decode #(.W(W)) u_dec (
    .q     (q_in),
    .phase (dec_phase),
    .legal (dec_legal)
  );

  assign succ = (phase == LAST) ? '0 : phase + 1'b1;
  assign pred = (phase == '0) ? LAST : phase - 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    vld_d   = 1'b0;
    ill_d   = illegal & ~err_clr;
    serr_d  = 1'b0;
    tick_d  = 1'b0;
`ifdef JPM_BIDIR_EN
    dir_d   = dir;
`else
    dir_d   = 1'b0;
`endif
    rcnt_d  = rev_count;
    err_inc = 1'b0;
    ecnt_d  = err_clr ? '0 : err_cnt;
    unique case (state_q)
      IDLE: begin
        if (!ld_in && dec_legal) begin
          state_d = TRACK;
          phase_d = dec_phase;
          vld_d   = 1'b1;
        end
      end
      TRACK: begin
        if (ld_in) begin
          state_d = IDLE;
        end else if (!dec_legal) begin
          state_d = FAULT;
          ill_d   = 1'b1;
        end else begin
          vld_d = 1'b1;
          if (dec_phase == phase) begin
            // stall: upstream held its value
          end else if (dec_phase == succ) begin
            phase_d = dec_phase;
            dir_d   = 1'b0;
            if (phase == LAST) begin
              tick_d = 1'b1;
              rcnt_d = rev_count + 1'b1;
            end
`ifdef JPM_BIDIR_EN
          end else if (dec_phase == pred) begin
            phase_d = dec_phase;
            dir_d   = 1'b1;
            if (phase == '0) begin
              tick_d = 1'b1;
              rcnt_d = rev_count - 1'b1;
            end
`endif
          end else begin
            serr_d  = 1'b1;
            err_inc = 1'b1;
            phase_d = dec_phase;
          end
        end
      end
      FAULT: begin
        if (err_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a fresh error in the same cycle as err_clr survives the clear
    if (err_inc)
      ecnt_d = err_clr ? CW'(1) : ((err_cnt == CMAX) ? err_cnt : err_cnt + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase     <= '0;
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      rev_tick  <= 1'b0;
      rev_count <= '0;
      dir       <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase     <= phase_d;
      phase_vld <= vld_d;
      illegal   <= ill_d;
      step_err  <= serr_d;
      err_cnt   <= ecnt_d;
      rev_tick  <= tick_d;
      rev_count <= rcnt_d;
      dir       <= dir_d;
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed-vector bench for johnson_phase_monitor (W=6, CW=8); honours JPM_BIDIR_EN.
module tb_johnson_phase_monitor;
  import jpm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] q_in = '0;
  logic       ld_in = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] phase;
  logic       phase_vld, illegal, step_err, rev_tick, dir;
  logic [7:0] err_cnt, rev_count;

  logic [5:0] dq;
  logic [3:0] dphase;
  logic       dlegal;

  int n_vec = 0;
  int n_err = 0;

  johnson_phase_monitor #(.W(6), .CW(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .ld_in(ld_in), .err_clr(err_clr),
    .phase(phase), .phase_vld(phase_vld), .illegal(illegal), .step_err(step_err),
    .err_cnt(err_cnt), .rev_tick(rev_tick), .rev_count(rev_count), .dir(dir)
  );

  johnson_decode #(.W(6)) u_ref_dec (.q(dq), .phase(dphase), .legal(dlegal));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] q, input logic ld, input logic clr);
    q_in = q; ld_in = ld; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".phase"}, phase, 0);
    chk({tag, ".vld"}, phase_vld, 0);
    chk({tag, ".illegal"}, illegal, 0);
    chk({tag, ".step_err"}, step_err, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".rev_tick"}, rev_tick, 0);
    chk({tag, ".rev_count"}, rev_count, 0);
    chk({tag, ".dir"}, dir, 0);
  endtask

  logic [5:0] codes [13] = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111,
                             6'b011111, 6'b111111, 6'b111110, 6'b111100, 6'b111000,
                             6'b110000, 6'b100000, 6'b000000};

  initial begin
    // standalone decoder spot checks
    dq = 6'b111110; #1; chk("dec_111110.ph", dphase, 7); chk("dec_111110.lg", dlegal, 1);
    dq = 6'b100000; #1; chk("dec_100000.ph", dphase, 11);
    dq = 6'b111111; #1; chk("dec_111111.ph", dphase, 6);
    dq = 6'b010101; #1; chk("dec_010101.lg", dlegal, 0);

    // 1: reset held with random q
    cyc(6'($urandom), 1'b0, 1'b0);
    cyc(6'($urandom), 1'b0, 1'b0);
    chk_zero("reset");
    reset = 1'b1;

    // 2: one full forward revolution
    for (int i = 0; i < 13; i++) begin
      cyc(codes[i], 1'b0, 1'b0);
      chk($sformatf("rev%0d.phase", i), phase, i % 12);
      chk($sformatf("rev%0d.vld", i), phase_vld, 1);
      chk($sformatf("rev%0d.step_err", i), step_err, 0);
      chk($sformatf("rev%0d.tick", i), rev_tick, (i == 12) ? 1 : 0);
    end
    chk("rev.rev_count", rev_count, 1);
    chk("rev.err_cnt", err_cnt, 0);
    cyc(6'b000000, 1'b0, 1'b0);
    chk("rev.tick_pulse", rev_tick, 0);

    // 3: illegal code -> FAULT, q ignored, err_clr exits
    cyc(6'b010101, 1'b0, 1'b0);
    chk("ill.illegal", illegal, 1);
    chk("ill.vld", phase_vld, 0);
    cyc(6'b000001, 1'b0, 1'b0);
    chk("fault.hold_ill", illegal, 1);
    chk("fault.vld", phase_vld, 0);
    chk("fault.step_err", step_err, 0);
    cyc(6'b000001, 1'b0, 1'b1);
    chk("clr.illegal", illegal, 0);
    chk("clr.vld", phase_vld, 0);

    // 4: skip 2 -> 4
    cyc(6'b000011, 1'b0, 1'b0);
    chk("skip.load_ph", phase, 2);
    chk("skip.load_vld", phase_vld, 1);
    chk("skip.load_serr", step_err, 0);
    cyc(6'b001111, 1'b0, 1'b0);
    chk("skip.step_err", step_err, 1);
    chk("skip.err_cnt", err_cnt, 1);
    chk("skip.phase", phase, 4);
    chk("skip.vld", phase_vld, 1);
    cyc(6'b001111, 1'b0, 1'b0);
    chk("skip.pulse", step_err, 0);

    // 5: load mode suspends checking
    for (int i = 0; i < 3; i++) begin
      cyc(6'b111000, 1'b1, 1'b0);
      chk($sformatf("ld%0d.vld", i), phase_vld, 0);
    end
    cyc(6'b000111, 1'b0, 1'b0);
    chk("ld.phase", phase, 3);
    chk("ld.vld", phase_vld, 1);
    chk("ld.step_err", step_err, 0);
    chk("ld.err_cnt", err_cnt, 1);
    cyc(6'b000111, 1'b0, 1'b1);
    chk("clr_track.err_cnt", err_cnt, 0);
    chk("clr_track.vld", phase_vld, 1);

    // mid-sequence reset
    reset = 1'b0;
    cyc(6'b001111, 1'b0, 1'b0);
    chk_zero("midrst");
    reset = 1'b1;

    // 6: reverse steps 1 -> 0 -> 11
    cyc(6'b000001, 1'b0, 1'b0);
    chk("bk.load_ph", phase, 1);
    cyc(6'b000000, 1'b0, 1'b0);
    chk("bk1.phase", phase, 0);
    chk("bk1.tick", rev_tick, 0);
`ifdef JPM_BIDIR_EN
    chk("bk1.dir", dir, 1);
    chk("bk1.step_err", step_err, 0);
`else
    chk("bk1.dir", dir, 0);
    chk("bk1.step_err", step_err, 1);
`endif
    cyc(6'b100000, 1'b0, 1'b0);
    chk("bk2.phase", phase, 11);
`ifdef JPM_BIDIR_EN
    chk("bk2.dir", dir, 1);
    chk("bk2.tick", rev_tick, 1);
    chk("bk2.rev_count", rev_count, 255);
    chk("bk2.err_cnt", err_cnt, 0);
`else
    chk("bk2.dir", dir, 0);
    chk("bk2.tick", rev_tick, 0);
    chk("bk2.rev_count", rev_count, 0);
    chk("bk2.step_err", step_err, 1);
    chk("bk2.err_cnt", err_cnt, 2);
`endif

    // simultaneous err_clr and new step error: error wins
    cyc(6'b000011, 1'b0, 1'b1);
    chk("race.step_err", step_err, 1);
    chk("race.err_cnt", err_cnt, 1);
    chk("race.phase", phase, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
